alu_register: RTL

ALU_REGISTER -- requirements
Module: alu_register

---
 rtl/alu_register_if.sv | 27 ++
 rtl/alu_register.sv | 105 ++++++++++
 2 files changed

// File: rtl/alu_register_if.sv
// alu_register_if: board-level I/O bundle for the ALU register demo.
//   KEY  : pushbuttons, active-low (KEY[0] reset, KEY[1] load)
//   SW   : slide switches (SW[3:0] operand A, SW[7:5] function F)
//   LEDR : LEDR[7:0] result R, LEDR[8] zero, LEDR[9] sticky carry C
//   HEX0..HEX5 : seven-segment digits, active-low segments {g,f,e,d,c,b,a}
// master drives KEY/SW and observes the displays; slave is the design side.
interface alu_register_if;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;

  modport master (
    output KEY, SW,
    input  LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  KEY, SW,
    output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/alu_register.sv
// alu_register: accumulator-style ALU with a debounced-edge load button.
//   CLOCK_50 : single clock, all state on rising edge
//   bus      : alu_register_if.slave
//     KEY[0] synchronous active-low reset, KEY[1] load button (active-low)
//     SW[3:0] operand A, SW[7:5] function F
//     LEDR = {C, 1'b0, R}; HEX0=A, HEX1=N, HEX2/3 blank, HEX4=R[3:0], HEX5=R[7:4]
// Operand B is R[3:0]. A press of KEY[1] produces exactly one load pulse,
// and R updates on the third rising edge after the button falls.
module alu_register (
  input logic           CLOCK_50,
  alu_register_if.slave bus
);

  logic       rst_n;
  logic       s1, s2, p;
  logic       load;
  logic [3:0] a, b;
  logic [2:0] f;
  logic [7:0] r;
  logic       c;
  logic [3:0] n;
  logic [4:0] sum5;
  logic [7:0] result;
  logic       unused_bits;

  assign rst_n = bus.KEY[0];
  assign a     = bus.SW[3:0];
  assign f     = bus.SW[7:5];
  assign b     = r[3:0];

  assign unused_bits = ^{bus.KEY[3:2], bus.SW[9:8], bus.SW[4]};

  // Press edge: synchronized level just went low while the delayed copy is high.
  assign load = ~s2 & p;

  assign sum5 = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = r;
    case (f)
      3'd0: result = {3'b000, sum5};
      3'd1: result = {a | b, a ^ b};
      3'd2: result = (|{a, b}) ? 8'h01 : 8'h00;
      3'd3: result = {a, b};
      3'd4: result = (a >= 4'd8) ? 8'h00 : (r << a);
      3'd5: result = (a >= 4'd8) ? 8'h00 : (r >> a);
      3'd6: result = {4'b0000, a} * {4'b0000, b};
      default: result = r;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      // Synchronizer cleared to "pressed" so a button held through reset
      // release cannot look like a fresh press edge.
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
      r  <= 8'h00;
      c  <= 1'b0;
      n  <= 4'd0;
    end else begin
      s1 <= bus.KEY[1];
      s2 <= s1;
      p  <= s2;
      if (load) begin
        r <= result;
        n <= n + 4'd1;
        if (f == 3'd0 && sum5[4]) begin
          c <= 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign bus.LEDR = {c, 1'b0, r};
  assign bus.HEX0 = hex7(a);
  assign bus.HEX1 = hex7(n);
  assign bus.HEX2 = 7'h7F;
  assign bus.HEX3 = 7'h7F;
  assign bus.HEX4 = hex7(r[3:0]);
  assign bus.HEX5 = hex7(r[7:4]);

endmodule
